// File: rtl/bus_merger_16bit.sv
`default_nettype none
// ============================================================================
// Module   : bus_merger_16bit
// Purpose  : Assembles 16-bit words from an 8-bit byte stream with
//            valid/ready handshakes on both sides and one buffered word.
//            A first byte flagged "last" closes the word early with zero- or
//            sign-extension of the missing upper (or lower) lane.
// Revision : 1.0 - initial release
// ============================================================================
module bus_merger_16bit #(
    parameter bit LOW_FIRST   = 1'b1,
    parameter bit EXTEND_SIGN = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        byte_last,
    output logic        byte_ready,
    output logic [15:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        half_full
);

    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_half  = 2'd1;
    localparam logic [1:0] c_st_full  = 2'd2;

    logic [1:0]  r_state;
    logic [7:0]  r_first;
    logic [15:0] r_word;
    logic        r_word_valid;
    logic        r_half_full;

    logic [1:0]  w_state_nxt;
    logic [7:0]  w_first_nxt;
    logic [15:0] w_word_nxt;
    logic [7:0]  w_ext;
    logic [15:0] w_early_word;
    logic [15:0] w_pair_word;
    logic        w_byte_xfer;
    logic        w_word_xfer;

    // A held word blocks new bytes unless the consumer drains it this same
    // edge; reset and clear both refuse bytes so nothing is half-accepted.
    assign byte_ready  = rst_n & ~clear & ((r_state != c_st_full) | word_ready);
    assign w_byte_xfer = byte_valid & byte_ready;
    assign w_word_xfer = r_word_valid & word_ready;

    assign word_out   = r_word;
    assign word_valid = r_word_valid;
    assign half_full  = r_half_full;

    // Fill pattern for the lane left empty by an early-closed word.
    generate
        if (EXTEND_SIGN) begin : g_ext_sign
            assign w_ext = {8{byte_in[7]}};
        end else begin : g_ext_zero
            assign w_ext = 8'h00;
        end
    endgenerate

    // Lane placement: the first byte lands in the low lane when LOW_FIRST.
    generate
        if (LOW_FIRST) begin : g_lane_low_first
            assign w_early_word = {w_ext, byte_in};
            assign w_pair_word  = {byte_in, r_first};
        end else begin : g_lane_high_first
            assign w_early_word = {byte_in, w_ext};
            assign w_pair_word  = {r_first, byte_in};
        end
    endgenerate

    // Next-state and datapath selection; word register only moves on completion.
    always_comb begin
        w_state_nxt = r_state;
        w_first_nxt = r_first;
        w_word_nxt  = r_word;
        case (r_state)
            c_st_empty: begin
                if (w_byte_xfer) begin
                    if (byte_last) begin
                        w_word_nxt  = w_early_word;
                        w_state_nxt = c_st_full;
                    end else begin
                        w_first_nxt = byte_in;
                        w_state_nxt = c_st_half;
                    end
                end
            end
            c_st_half: begin
                // A second byte always completes the word; its last flag is moot.
                if (w_byte_xfer) begin
                    w_word_nxt  = w_pair_word;
                    w_state_nxt = c_st_full;
                end
            end
            c_st_full: begin
                if (w_word_xfer) begin
                    // Pass-through: a byte arriving while the word drains is
                    // handled as the first byte of the next word.
                    if (w_byte_xfer) begin
                        if (byte_last) begin
                            w_word_nxt  = w_early_word;
                            w_state_nxt = c_st_full;
                        end else begin
                            w_first_nxt = byte_in;
                            w_state_nxt = c_st_half;
                        end
                    end else begin
                        w_state_nxt = c_st_empty;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_empty;
            end
        endcase
        // Flush drops any partial or held word; word_out keeps its last value.
        if (clear) begin
            w_state_nxt = c_st_empty;
        end
    end

    // State, lane and flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_st_empty;
            r_first      <= 8'h00;
            r_word       <= 16'h0000;
            r_word_valid <= 1'b0;
            r_half_full  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_first      <= w_first_nxt;
            r_word       <= w_word_nxt;
            r_word_valid <= (w_state_nxt == c_st_full);
            r_half_full  <= (w_state_nxt == c_st_half);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_merger_16bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_merger_16bit
// Purpose  : Self-checking bench for bus_merger_16bit. Three instances cover
//            lane order and extension variants; a word-level model predicts
//            every output each cycle, directed literals pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_merger_16bit;

    localparam int c_n = 3;
    // Instance configs: 0 = low-first/zero, 1 = high-first/sign, 2 = low-first/sign
    localparam bit c_lf [c_n] = '{1'b1, 1'b0, 1'b1};
    localparam bit c_es [c_n] = '{1'b0, 1'b1, 1'b1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_last;
    logic        word_ready;

    logic        br [c_n];
    logic [15:0] wo [c_n];
    logic        wv [c_n];
    logic        hf [c_n];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model: is a finished word held, is a first byte pending, and their values
    bit          m_wv [c_n];
    bit          m_hf [c_n];
    logic [7:0]  m_first [c_n];
    logic [15:0] m_word [c_n];

    always #5 clk = ~clk;

    bus_merger_16bit #(.LOW_FIRST(1'b1), .EXTEND_SIGN(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(br[0]),
        .word_out(wo[0]), .word_valid(wv[0]), .word_ready(word_ready), .half_full(hf[0]));

    bus_merger_16bit #(.LOW_FIRST(1'b0), .EXTEND_SIGN(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(br[1]),
        .word_out(wo[1]), .word_valid(wv[1]), .word_ready(word_ready), .half_full(hf[1]));

    bus_merger_16bit #(.LOW_FIRST(1'b1), .EXTEND_SIGN(1'b1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(br[2]),
        .word_out(wo[2]), .word_valid(wv[2]), .word_ready(word_ready), .half_full(hf[2]));

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Word-level model: pair bytes into words by arrival order.
    always @(posedge clk) begin
        chk_en <= 1'b1;
        for (int k = 0; k < c_n; k++) begin
            automatic bit         can_take = !m_wv[k] || word_ready;
            automatic logic [7:0] fill;
            if (!rst_n) begin
                m_wv[k] = 1'b0; m_hf[k] = 1'b0; m_first[k] = 8'h00; m_word[k] = 16'h0000;
            end else if (clear) begin
                m_wv[k] = 1'b0; m_hf[k] = 1'b0;
            end else begin
                if (m_wv[k] && word_ready) m_wv[k] = 1'b0;
                if (byte_valid && can_take) begin
                    if (m_hf[k]) begin
                        m_word[k] = c_lf[k] ? {byte_in, m_first[k]} : {m_first[k], byte_in};
                        m_wv[k] = 1'b1; m_hf[k] = 1'b0;
                    end else if (byte_last) begin
                        fill = (c_es[k] && byte_in[7]) ? 8'hFF : 8'h00;
                        m_word[k] = c_lf[k] ? {fill, byte_in} : {byte_in, fill};
                        m_wv[k] = 1'b1;
                    end else begin
                        m_first[k] = byte_in; m_hf[k] = 1'b1;
                    end
                end
            end
        end
    end

    // Compare every output of every instance against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < c_n; k++) begin
                chk($sformatf("cyc%0d.word_out", k), wo[k], m_word[k]);
                chk($sformatf("cyc%0d.word_valid", k), {15'd0, wv[k]}, {15'd0, m_wv[k]});
                chk($sformatf("cyc%0d.half_full", k), {15'd0, hf[k]}, {15'd0, m_hf[k]});
                chk($sformatf("cyc%0d.byte_ready", k), {15'd0, br[k]},
                    {15'd0, rst_n && !clear && (!m_wv[k] || word_ready)});
            end
        end
    end

    task automatic drive(input bit v, input logic [7:0] b, input bit l, input bit wr, input bit clr);
        byte_valid = v; byte_in = b; byte_last = l; word_ready = wr; clear = clr;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
        byte_last = 1'b0; word_ready = 1'b0;
        tick(); tick();
        // Reset state
        drive(1, 8'hAA, 0, 1, 0);
        chk("rst.word_out", wo[0], 16'h0000);
        chk("rst.word_valid", {15'd0, wv[0]}, 16'd0);
        chk("rst.half_full", {15'd0, hf[0]}, 16'd0);
        chk("rst.byte_ready", {15'd0, br[0]}, 16'd0);
        tick();
        rst_n = 1'b1;
        drive(0, 8'h00, 0, 1, 0);
        chk("post_rst.byte_ready", {15'd0, br[0]}, 16'd1);
        tick();

        // Two-byte word 34,12
        drive(1, 8'h34, 0, 1, 0); tick();
        drive(1, 8'h12, 0, 1, 0);
        chk("pair.half_full", {15'd0, hf[0]}, 16'd1);
        tick();
        drive(0, 8'h00, 0, 1, 0);
        chk("pair.lowfirst", wo[0], 16'h1234);
        chk("pair.highfirst", wo[1], 16'h3412);
        chk("pair.word_valid", {15'd0, wv[0]}, 16'd1);
        tick();
        drive(0, 8'h00, 0, 1, 0);
        chk("pair.drained", {15'd0, wv[0]}, 16'd0);
        tick();

        // Early-closed word from 0x80
        drive(1, 8'h80, 1, 1, 0); tick();
        drive(0, 8'h00, 0, 1, 0);
        chk("early.zero_ext", wo[0], 16'h0080);
        chk("early.sign_hi", wo[1], 16'h80FF);
        chk("early.sign_lo", wo[2], 16'hFF80);
        tick();

        // Backpressure
        drive(1, 8'h34, 0, 0, 0); tick();
        drive(1, 8'h12, 0, 0, 0); tick();
        drive(1, 8'hAB, 0, 0, 0);
        chk("bp.byte_ready", {15'd0, br[0]}, 16'd0);
        chk("bp.held", wo[0], 16'h1234);
        tick();
        drive(1, 8'hAB, 0, 1, 0);
        chk("bp.passthru_ready", {15'd0, br[0]}, 16'd1);
        chk("bp.still_held", wo[0], 16'h1234);
        tick();
        drive(0, 8'h00, 0, 1, 0);
        chk("bp.half_after", {15'd0, hf[0]}, 16'd1);
        chk("bp.valid_after", {15'd0, wv[0]}, 16'd0);
        tick();
        drive(0, 8'h00, 0, 1, 1);
        chk("clr.byte_ready", {15'd0, br[0]}, 16'd0);
        tick();
        drive(0, 8'h00, 0, 1, 0);
        chk("clr.half_full", {15'd0, hf[0]}, 16'd0);
        tick();

        // Flush discards a partial byte
        drive(1, 8'h55, 0, 1, 0); tick();
        drive(1, 8'h99, 0, 1, 1); tick();
        drive(1, 8'h66, 0, 1, 0); tick();
        drive(1, 8'h77, 0, 1, 0); tick();
        drive(0, 8'h00, 0, 1, 0);
        chk("flush.word", wo[0], 16'h7766);
        chk("flush.word_hi", wo[1], 16'h6677);
        tick();

        // Back-to-back early-closed bytes, one word per cycle
        for (int i = 1; i <= 8; i++) begin
            drive(1, 8'(i), 1, 1, 0);
            if (i > 1) begin
                chk("stream.word", wo[0], 16'(i - 1));
                chk("stream.valid", {15'd0, wv[0]}, 16'd1);
            end
            tick();
        end
        drive(0, 8'h00, 0, 1, 0);
        chk("stream.last", wo[0], 16'h0008);
        chk("stream.last_hi", wo[1], 16'h0800);
        tick();

        // Random stall soak against the model
        for (int i = 0; i < 600; i++) begin
            rst_n = (i != 300);
            drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
            tick();
        end
        rst_n = 1'b1;
        drive(0, 8'h00, 0, 1, 0); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
